// File: rtl/systolic_mm_sequencer.sv
// Sequences one C = A x B pass over a ROWS x COLS output-stationary systolic array:
// operand buffers, diagonally skewed feed, accumulator drain and a valid/ready result stream.
module systolic_mm_sequencer #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [7:0]               cfg_m,
  input  logic [7:0]               cfg_n,
  input  logic [7:0]               cfg_k,
  output logic                     busy,
  output logic                     err,
  output logic                     done,
  input  logic                     a_we,
  input  logic [$clog2(ROWS)-1:0]  a_row,
  input  logic [$clog2(K_MAX)-1:0] a_col,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_we,
  input  logic [$clog2(K_MAX)-1:0] b_row,
  input  logic [$clog2(COLS)-1:0]  b_col,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     arr_reset,
  output logic                     arr_through,
  output logic [ROWS*DATA_W-1:0]   arr_left,
  output logic [COLS*DATA_W-1:0]   arr_top,
  input  logic [COLS*DATA_W-1:0]   arr_down,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_row,
  output logic [COLS*DATA_W-1:0]   res_data,
  output logic                     res_last
);

  localparam int RA_W  = $clog2(ROWS);
  localparam int KA_W  = $clog2(K_MAX);
  localparam int CNT_W = $clog2(K_MAX + ROWS + COLS);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         row_q, row_d;
  logic [7:0]         m_q, n_q, k_q;
  logic               cfg_ok;
  logic [CNT_W-1:0]   feed_last;
  logic [RA_W-1:0]    drain_row;
  logic [ROWS*DATA_W-1:0] left_d;
  logic [COLS*DATA_W-1:0] top_d;
  logic [COLS*DATA_W-1:0] drain_word;

  logic [DATA_W-1:0]      a_mem [ROWS][K_MAX];
  logic [DATA_W-1:0]      b_mem [K_MAX][COLS];
  logic [COLS*DATA_W-1:0] c_mem [ROWS];

  assign cfg_ok = (cfg_m != 8'd0) && (cfg_m <= 8'(ROWS)) &&
                  (cfg_n != 8'd0) && (cfg_n <= 8'(COLS)) &&
                  (cfg_k != 8'd0) && (cfg_k <= 8'(K_MAX));

  // Last feed step lets the final operand pair reach the far corner PE.
  assign feed_last = CNT_W'(k_q) + CNT_W'(ROWS + COLS - 2);
  assign drain_row = RA_W'(CNT_W'(ROWS) - cnt_q);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    busy        = (state_q != IDLE);
    arr_reset   = 1'b0;
    arr_through = 1'b0;
    res_valid   = 1'b0;
    res_last    = 1'b0;
    res_row     = 8'd0;
    res_data    = '0;
    case (state_q)
      IDLE:  if (start && cfg_ok) state_d = CLEAR;
      CLEAR: begin
        arr_reset = 1'b1;
        state_d   = FEED;
        cnt_d     = '0;
      end
      FEED: begin
        if (cnt_q == feed_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        arr_through = (cnt_q < CNT_W'(ROWS));
        if (cnt_q == CNT_W'(ROWS)) begin
          state_d = OUT;
          row_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        res_valid = 1'b1;
        res_last  = (row_q == m_q - 8'd1);
        res_row   = row_q;
        res_data  = c_mem[row_q[RA_W-1:0]];
        if (res_ready) begin
          if (row_q == m_q - 8'd1) state_d = IDLE;
          else                     row_d   = row_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skewed operands for the feed step about to start, so the edge registers them on time.
  always_comb begin
    left_d = '0;
    top_d  = '0;
    if (state_d == FEED) begin
      for (int i = 0; i < ROWS; i++) begin
        if ((8'(i) < m_q) && (cnt_d >= CNT_W'(i)) && ((cnt_d - CNT_W'(i)) < CNT_W'(k_q)))
          left_d[i*DATA_W +: DATA_W] = a_mem[i][KA_W'(cnt_d - CNT_W'(i))];
      end
      for (int j = 0; j < COLS; j++) begin
        if ((8'(j) < n_q) && (cnt_d >= CNT_W'(j)) && ((cnt_d - CNT_W'(j)) < CNT_W'(k_q)))
          top_d[j*DATA_W +: DATA_W] = b_mem[KA_W'(cnt_d - CNT_W'(j))][j];
      end
    end
  end

  always_comb begin
    drain_word = '0;
    if (8'(drain_row) < m_q) begin
      for (int j = 0; j < COLS; j++) begin
        if (8'(j) < n_q) drain_word[j*DATA_W +: DATA_W] = arr_down[j*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= 8'd0;
      m_q      <= 8'd0;
      n_q      <= 8'd0;
      k_q      <= 8'd0;
      err      <= 1'b0;
      done     <= 1'b0;
      arr_left <= '0;
      arr_top  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      err      <= (state_q == IDLE) && start && !cfg_ok;
      done     <= (state_q == OUT) && res_ready && (row_q == m_q - 8'd1);
      arr_left <= left_d;
      arr_top  <= top_d;
      if ((state_q == IDLE) && start && cfg_ok) begin
        m_q <= cfg_m;
        n_q <= cfg_n;
        k_q <= cfg_k;
      end
    end
  end

  // NOTE: buffers have no reset; their contents must survive reset and they map to plain RAM.
  always_ff @(posedge clk) begin
    if (a_we && (state_q == IDLE)) a_mem[a_row][a_col] <= a_data;
    if (b_we && (state_q == IDLE)) b_mem[b_row][b_col] <= b_data;
    if ((state_q == DRAIN) && (cnt_q != '0)) c_mem[drain_row] <= drain_word;
  end

endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// Directed bench for systolic_mm_sequencer with a behavioural 4x4 output-stationary array
// model on the arr_* ports; expected results are hand-computed constants.
module tb_systolic_mm_sequencer;
  localparam int ROWS = 4, COLS = 4, K_MAX = 16, DATA_W = 8;
  localparam int RW = COLS * DATA_W;

  logic clk = 1'b0;
  logic reset_n, start;
  logic [7:0] cfg_m, cfg_n, cfg_k;
  logic busy, err, done;
  logic a_we, b_we;
  logic [1:0] a_row, b_col;
  logic [3:0] a_col, b_row;
  logic [7:0] a_data, b_data;
  logic arr_reset, arr_through;
  logic [ROWS*DATA_W-1:0] arr_left;
  logic [RW-1:0] arr_top, arr_down;
  logic res_valid, res_ready, res_last;
  logic [7:0] res_row;
  logic [RW-1:0] res_data;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_mm_sequencer #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .busy(busy), .err(err), .done(done),
    .a_we(a_we), .a_row(a_row), .a_col(a_col), .a_data(a_data),
    .b_we(b_we), .b_row(b_row), .b_col(b_col), .b_data(b_data),
    .arr_reset(arr_reset), .arr_through(arr_through),
    .arr_left(arr_left), .arr_top(arr_top), .arr_down(arr_down),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
    .res_data(res_data), .res_last(res_last)
  );

  // Array model: operands move right/down, accumulators add while not in through mode,
  // and in through mode shift down into a registered bottom output.
  logic [DATA_W-1:0] pa [ROWS][COLS];
  logic [DATA_W-1:0] pb [ROWS][COLS];
  logic [DATA_W-1:0] acc [ROWS][COLS];
  logic [DATA_W-1:0] down_q [COLS];
  logic [DATA_W-1:0] m_ain, m_bin;

  always @(posedge clk) begin
    if (arr_reset) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          pa[i][j] <= '0; pb[i][j] <= '0; acc[i][j] <= '0;
        end
      for (int j = 0; j < COLS; j++) down_q[j] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          if (j == 0) m_ain = arr_left[i*DATA_W +: DATA_W]; else m_ain = pa[i][j-1];
          if (i == 0) m_bin = arr_top[j*DATA_W +: DATA_W];  else m_bin = pb[i-1][j];
          pa[i][j] <= m_ain;
          pb[i][j] <= m_bin;
          if (arr_through) begin
            if (i == 0) acc[i][j] <= '0; else acc[i][j] <= acc[i-1][j];
          end else begin
            acc[i][j] <= acc[i][j] + m_ain * m_bin;
          end
        end
      if (arr_through) for (int j = 0; j < COLS; j++) down_q[j] <= acc[ROWS-1][j];
    end
  end

  always_comb begin
    arr_down = '0;
    for (int j = 0; j < COLS; j++) arr_down[j*DATA_W +: DATA_W] = down_q[j];
  end

  // Observations from the most recent run_mm call.
  logic [RW-1:0] got_data [ROWS];
  logic [7:0]    got_row  [ROWS];
  logic          got_last [ROWS];
  int got_cnt, first_valid_cyc, done_cyc, done_pulses, unstable, err_seen, timeout;
  logic busy_at1, clr_at1, busy_at_done, valid_after;

  function automatic logic [RW-1:0] id_row(input int r);
    case (r)
      0: return 32'h04030201;
      1: return 32'h08070605;
      2: return 32'h0c0b0a09;
      default: return 32'h100f0e0d;
    endcase
  endfunction

  task automatic write_ab(input int ar, input int ac, input logic [7:0] ad,
                          input int br, input int bc, input logic [7:0] bd);
    @(negedge clk);
    a_we = 1'b1; a_row = 2'(ar); a_col = 4'(ac); a_data = ad;
    b_we = 1'b1; b_row = 4'(br); b_col = 2'(bc); b_data = bd;
    @(negedge clk);
    a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic load_identity;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_ab(r, c, (r == c) ? 8'd1 : 8'd0, r, c, 8'(4 * r + c + 1));
  endtask

  // Issues start (accepted at edge 0), then drains results; stall = cycles of res_ready=0 per row.
  task automatic run_mm(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k,
                        input int stall, input bit poke);
    int cyc;
    logic [RW-1:0] snap_data;
    logic [7:0] snap_row;
    got_cnt = 0; unstable = 0; err_seen = 0; timeout = 0; done_pulses = 0;
    first_valid_cyc = -1; done_cyc = -1; busy_at_done = 1'b1;
    @(negedge clk);
    cfg_m = m; cfg_n = n; cfg_k = k; start = 1'b1; res_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0; cyc = 1;
    busy_at1 = busy; clr_at1 = arr_reset;
    while (!res_valid && cyc < 300) begin
      if (poke && cyc == 3) begin
        a_we = 1'b1; a_row = 2'd3; a_col = 4'd3; a_data = 8'hAA;
        b_we = 1'b1; b_row = 4'd3; b_col = 2'd3; b_data = 8'h55;
        start = 1'b1; cfg_k = 8'd0;
      end
      if (poke && cyc == 4) begin
        a_we = 1'b0; b_we = 1'b0; start = 1'b0; cfg_k = k;
      end
      if (err) err_seen++;
      @(negedge clk); cyc++;
    end
    if (!res_valid) begin
      timeout = 1;
      return;
    end
    first_valid_cyc = cyc;
    while (res_valid && got_cnt < ROWS && cyc < 600) begin
      if (stall > 0) begin
        snap_data = res_data; snap_row = res_row;
        repeat (stall) begin
          @(negedge clk); cyc++;
          if (!res_valid || res_data !== snap_data || res_row !== snap_row) unstable++;
        end
      end
      got_data[got_cnt] = res_data; got_row[got_cnt] = res_row; got_last[got_cnt] = res_last;
      got_cnt++;
      res_ready = 1'b1;
      @(negedge clk); cyc++;
      if (done) begin done_pulses++; done_cyc = cyc; busy_at_done = busy; end
      if (stall > 0) res_ready = 1'b0;
    end
    res_ready = 1'b0;
    valid_after = res_valid;
    repeat (4) begin
      @(negedge clk);
      if (done) done_pulses++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, err, done, arr_reset, arr_through, res_valid, res_last} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000",
                         {busy, err, done, arr_reset, arr_through, res_valid, res_last});
    end
    n_checks++;
    if ({arr_left, arr_top} !== '0) begin
      n_fail++; $display("FAIL reset_operands: got %h expected 0", {arr_left, arr_top});
    end
    n_checks++;
    if ({res_row, res_data} !== '0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 0", {res_row, res_data});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_identity;
    load_identity();
    run_mm(8'd4, 8'd4, 8'd4, 0, 1'b0);
    n_checks++;
    if (timeout != 0) begin n_fail++; $display("FAIL id_timeout: got %0d expected 0", timeout); end
    n_checks++;
    if ({busy_at1, clr_at1} !== 2'b11) begin
      n_fail++; $display("FAIL id_clear_cycle: got busy,arr_reset=%b expected 11", {busy_at1, clr_at1});
    end
    n_checks++;
    if (first_valid_cyc != 18) begin
      n_fail++; $display("FAIL id_first_valid: got cycle %0d expected 18", first_valid_cyc);
    end
    n_checks++;
    if (got_cnt != 4) begin n_fail++; $display("FAIL id_rows: got %0d expected 4", got_cnt); end
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if ({got_row[r], got_last[r], got_data[r]} !== {8'(r), 1'(r == 3), id_row(r)}) begin
        n_fail++; $display("FAIL id_row%0d: got row=%0d last=%b data=%h expected row=%0d last=%b data=%h",
                           r, got_row[r], got_last[r], got_data[r], r, (r == 3), id_row(r));
      end
    end
    n_checks++;
    if (done_cyc != 22 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL id_done_timing: got cycle %0d busy %b expected cycle 22 busy 0",
                         done_cyc, busy_at_done);
    end
    n_checks++;
    if (done_pulses != 1) begin n_fail++; $display("FAIL id_done_pulses: got %0d expected 1", done_pulses); end
    n_checks++;
    if (valid_after !== 1'b0) begin n_fail++; $display("FAIL id_valid_after: got %b expected 0", valid_after); end
  endtask

  task automatic test_partial;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        write_ab(r, c, 8'd1, c, r, 8'd1);
    run_mm(8'd2, 8'd3, 8'd5, 0, 1'b0);
    n_checks++;
    if (first_valid_cyc != 19) begin
      n_fail++; $display("FAIL part_first_valid: got cycle %0d expected 19", first_valid_cyc);
    end
    n_checks++;
    if (got_cnt != 2) begin n_fail++; $display("FAIL part_rows: got %0d expected 2", got_cnt); end
    for (int r = 0; r < 2; r++) begin
      n_checks++;
      if ({got_row[r], got_last[r], got_data[r]} !== {8'(r), 1'(r == 1), 32'h00050505}) begin
        n_fail++; $display("FAIL part_row%0d: got row=%0d last=%b data=%h expected row=%0d last=%b data=00050505",
                           r, got_row[r], got_last[r], got_data[r], r, (r == 1));
      end
    end
    n_checks++;
    if (done_cyc != 21 || done_pulses != 1) begin
      n_fail++; $display("FAIL part_done: got cycle %0d pulses %0d expected cycle 21 pulses 1",
                         done_cyc, done_pulses);
    end
  endtask

  task automatic test_wrap_backpressure;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_ab(r, c, 8'hFF, r, c, 8'hFF);
    run_mm(8'd4, 8'd4, 8'd4, 5, 1'b0);
    n_checks++;
    if (first_valid_cyc != 18) begin
      n_fail++; $display("FAIL wrap_first_valid: got cycle %0d expected 18", first_valid_cyc);
    end
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL wrap_stable: got %0d unstable samples expected 0", unstable); end
    n_checks++;
    if (got_cnt != 4) begin n_fail++; $display("FAIL wrap_handshakes: got %0d expected 4", got_cnt); end
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if ({got_row[r], got_last[r], got_data[r]} !== {8'(r), 1'(r == 3), 32'h04040404}) begin
        n_fail++; $display("FAIL wrap_row%0d: got row=%0d last=%b data=%h expected row=%0d last=%b data=04040404",
                           r, got_row[r], got_last[r], got_data[r], r, (r == 3));
      end
    end
    n_checks++;
    if (done_pulses != 1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL wrap_done: got pulses %0d busy %b expected pulses 1 busy 0", done_pulses, busy_at_done);
    end
  endtask

  task automatic test_illegal;
    int errs, busys, clrs;
    for (int v = 0; v < 3; v++) begin
      errs = 0; busys = 0; clrs = 0;
      @(negedge clk);
      cfg_m = (v == 1) ? 8'd5 : 8'd4;
      cfg_n = 8'd4;
      cfg_k = (v == 0) ? 8'd0 : ((v == 2) ? 8'd17 : 8'd4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
        if (err) errs++;
        if (busy) busys++;
        if (arr_reset) clrs++;
        @(negedge clk);
      end
      n_checks++;
      if (errs != 1) begin n_fail++; $display("FAIL illegal%0d_err: got %0d pulses expected 1", v, errs); end
      n_checks++;
      if (busys != 0) begin n_fail++; $display("FAIL illegal%0d_busy: got %0d busy cycles expected 0", v, busys); end
      n_checks++;
      if (clrs != 0) begin n_fail++; $display("FAIL illegal%0d_clear: got %0d arr_reset cycles expected 0", v, clrs); end
    end
  endtask

  task automatic test_writes_while_busy;
    load_identity();
    for (int pass = 0; pass < 2; pass++) begin
      run_mm(8'd4, 8'd4, 8'd4, 0, (pass == 0));
      n_checks++;
      if (got_cnt != 4 || err_seen != 0) begin
        n_fail++; $display("FAIL wbusy%0d_count: got rows %0d err %0d expected rows 4 err 0", pass, got_cnt, err_seen);
      end
      for (int r = 0; r < 4; r++) begin
        n_checks++;
        if (got_data[r] !== id_row(r)) begin
          n_fail++; $display("FAIL wbusy%0d_row%0d: got %h expected %h", pass, r, got_data[r], id_row(r));
        end
      end
    end
  endtask

  task automatic test_reset_mid_feed;
    int cyc;
    @(negedge clk);
    cfg_m = 8'd4; cfg_n = 8'd4; cfg_k = 8'd4; start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 6) begin @(negedge clk); cyc++; end
    n_checks++;
    if ({busy, arr_left, arr_top} !== {1'b1, 32'h00010000, 32'h080b0e00}) begin
      n_fail++; $display("FAIL midfeed_t4: got busy=%b left=%h top=%h expected busy=1 left=00010000 top=080b0e00",
                         busy, arr_left, arr_top);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, err, done, arr_reset, arr_through, res_valid, res_last} !== 7'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b expected 0000000",
                         {busy, err, done, arr_reset, arr_through, res_valid, res_last});
    end
    n_checks++;
    if ({arr_left, arr_top, res_row, res_data} !== '0) begin
      n_fail++; $display("FAIL midreset_data: got %h expected 0", {arr_left, arr_top, res_row, res_data});
    end
    reset_n = 1'b1;
    res_ready = 1'b0;
    run_mm(8'd4, 8'd4, 8'd4, 0, 1'b0);
    n_checks++;
    if (clr_at1 !== 1'b1 || first_valid_cyc != 18) begin
      n_fail++; $display("FAIL midreset_rerun: got arr_reset@1=%b first_valid=%0d expected 1 and 18",
                         clr_at1, first_valid_cyc);
    end
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if (got_data[r] !== id_row(r)) begin
        n_fail++; $display("FAIL midreset_row%0d: got %h expected %h", r, got_data[r], id_row(r));
      end
    end
    n_checks++;
    if (done_pulses != 1) begin n_fail++; $display("FAIL midreset_done: got %0d expected 1", done_pulses); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    cfg_m = 8'd0; cfg_n = 8'd0; cfg_k = 8'd0;
    a_we = 1'b0; a_row = '0; a_col = '0; a_data = '0;
    b_we = 1'b0; b_row = '0; b_col = '0; b_data = '0;
    test_reset();
    test_identity();
    test_partial();
    test_wrap_backpressure();
    test_illegal();
    test_writes_while_busy();
    test_reset_mid_feed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_mm_sequencer.md
# systolic_mm_sequencer

- Parametrised control block that runs one matrix multiply C = A x B on the ROWS x COLS systolic array.
- Holds A and B operands in internal buffers loaded through write ports, and feeds them to the array with diagonal skew.
- Drains the array accumulators into a result buffer and streams C out row by row with a valid/ready handshake.
- Sits between the host-side load/command logic and the array; it replaces the free-running counter sequencing with a start/done handshake, run-time sizes (m, n, k) and output backpressure.

## Interface
- ROWS, 4, array rows; maximum m
- COLS, 4, array columns; maximum n
- K_MAX, 16, maximum inner dimension k
- DATA_W, 8, operand and result width (unsigned)
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command pulse; sampled only in IDLE
- cfg_m / cfg_n / cfg_k  in  8 each  rows of A, columns of B, inner dimension
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse when start is rejected
- done  out  1  one-cycle pulse after the last result handshake
- a_we, a_row[$clog2(ROWS)], a_col[$clog2(K_MAX)], a_data[DATA_W]  in  A buffer write port
- b_we, b_row[$clog2(K_MAX)], b_col[$clog2(COLS)], b_data[DATA_W]  in  B buffer write port
- arr_reset  out  1  active-high clear of the PE accumulators
- arr_through  out  1  array drain/shift mode
- arr_left  out  ROWS*DATA_W  left-edge operands; row i occupies slice i
- arr_top  out  COLS*DATA_W  top-edge operands; column j occupies slice j
- arr_down  in  COLS*DATA_W  bottom-edge array output
- res_valid  out  1, res_ready  in  1  result handshake
- res_row  out  8, res_data  out  COLS*DATA_W, res_last  out  1  result row index, row data, last-row flag

## Operation
- **FSM states:** IDLE, CLEAR, FEED, DRAIN, OUT.
- **IDLE:** start=1 with 1<=m<=ROWS, 1<=n<=COLS and 1<=k<=K_MAX latches the config and moves to CLEAR. Any other value in any field pulses err for one cycle and the FSM stays in IDLE.
- **Operand writes:** accepted only while busy=0. Writes during busy are dropped. A write and an accepted start in the same cycle: the write lands before FEED reads the buffers. Buffer contents survive runs and reset.
- **CLEAR:** one cycle with arr_reset=1, then FEED.
- **FEED:** feed counter t = 0 .. k+ROWS+COLS-2 (k+ROWS+COLS-1 cycles).
  - Row i: arr_left[i] = A[i][t-i] when i<m and i<=t<=i+k-1, else 0.
  - Column j: arr_top[j] = B[t-j][j] when j<n and j<=t<=j+k-1, else 0.
  - Outputs are registered.
- **DRAIN:** ROWS+1 cycles, d = 0..ROWS.
  - arr_through=1 for d = 0..ROWS-1, 0 at d = ROWS.
  - For d>=1, arr_down is captured into C row ROWS-d.
  - Rows >= m and columns >= n are stored as 0.
- **OUT:** rows r = 0..m-1 are presented in order.
  - res_row = r and res_data = C[r]; res_last = 1 when r = m-1.
  - A row advances only on res_valid && res_ready.
  - After the last handshake: done pulses for one cycle, state returns to IDLE.
- **Arithmetic:** unsigned; C[r][c] = sum of A[r][x]*B[x][c] mod 2^DATA_W, the truncation performed by the PEs.

## Timing
- **Reset values:** state IDLE. busy, err, done, arr_reset, arr_through, res_valid and res_last are 0. arr_left, arr_top, res_data and res_row are 0.
- **Reset mid-operation:** the same values apply on the next edge and the run is abandoned. The first start after reset re-clears the array via CLEAR.
- **Cycle numbering:** start is accepted at edge 0.
  - CLEAR at cycle 1.
  - FEED at cycles 2 .. k+ROWS+COLS.
  - DRAIN at cycles k+ROWS+COLS+1 .. k+2*ROWS+COLS+1.
  - First res_valid at cycle k+2*ROWS+COLS+2 (18 for 4x4, k=4).
- **Backpressure:** res_valid stays high and res_data stays stable while res_ready=0. No bubble between back-to-back handshakes.
- **done timing:** done asserts the cycle after the final handshake, with busy=0 in that same cycle. A start in that cycle is accepted.
- **start while busy:** ignored; no err pulse.

## Test plan
- **Identity:** A = I4, B[x][c] = 4x+c+1, m=n=k=4 -> rows out {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}. First res_valid at cycle 18; done one cycle after row 3 handshakes.
- **Partial size:** m=2, n=3, k=5, all operands = 1 -> two rows of {5,5,5,0}; res_last on row 1.
- **Wrap and backpressure:** all operands = 255, k=4 (result 4*65025 mod 256 = 4). Hold res_ready=0 for 5 cycles per row -> data stable each row, exactly 4 handshakes, one done pulse.
- **Illegal config:** start with k=0, then m=5 -> one err pulse each, busy stays 0, no arr_reset pulse.
- **Writes while busy:** A and B writes during FEED are dropped -> second run with identical config produces identical results.
- **Reset mid-FEED:** reset_n=0 at cycle 6 -> all outputs at reset values next cycle. A new start then gives the correct identity result.
